sram_port_arbiter: RTL

- Shares the single sram_like data-memory master port between the instruction-fetch requester and the MEM-stage load/store requester.
- Sits between the CPU pipeline and the sram_like-to-AXI bridge.
- Allows one outstanding transaction at a time. Data has fixed priority, with a starvation limiter that guarantees instruction-fetch progress.
- Requester-side signals keep exact sram_like semantics, so the MEM stage's req/addr_ok/data_ok handshake is unchanged.

---
 rtl/sram_arb_pkg.sv | 18 +
 rtl/sram_arb_pick.sv | 40 ++++
 rtl/sram_port_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared encodings for the sram_like port arbiter: FSM states, grant
// owner and transfer sizes.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic GNT_INST = 1'b0;
    localparam logic GNT_DATA = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/sram_arb_pick.sv
// Winner selection between the fetch and MEM requesters, plus the value the
// starvation counter takes if the current pick is accepted.
module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic             inst_req,
    input  logic             data_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             pick_valid,
    output logic             pick_grant,
    output logic [CNT_W-1:0] cnt_next
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    // Data has priority unless fetch has already been passed over LIMIT times.
    always_comb begin
        pick_valid = inst_req | data_req;
        pick_grant = GNT_INST;
        cnt_next   = {CNT_W{1'b0}};
        if (data_req && !(inst_req && (starve_cnt == LIMIT))) begin
            pick_grant = GNT_DATA;
        end else begin
            pick_grant = GNT_INST;
        end
        if ((pick_grant == GNT_DATA) && inst_req) begin
            if (starve_cnt == LIMIT) begin
                cnt_next = LIMIT;
            end else begin
                cnt_next = starve_cnt + CNT_W'(1);
            end
        end else begin
            cnt_next = {CNT_W{1'b0}};
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one sram_like master port between instruction fetch and the MEM
// stage, one outstanding transaction at a time.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    state_t             state_r;
    logic               grant_r;
    logic [CNT_W-1:0]   starve_cnt_r;
    logic               wr_r;
    logic [1:0]         size_r;
    logic [31:0]        addr_r;
    logic [31:0]        wdata_r;

    logic               pick_valid_s;
    logic               pick_grant_s;
    logic [CNT_W-1:0]   cnt_next_s;
    logic               in_idle_s;
    logic               in_req_s;
    logic               done_s;

    sram_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_pick (
        .inst_req   (inst_req),
        .data_req   (data_req),
        .starve_cnt (starve_cnt_r),
        .pick_valid (pick_valid_s),
        .pick_grant (pick_grant_s),
        .cnt_next   (cnt_next_s)
    );

    assign in_idle_s = (state_r == ST_IDLE);
    assign in_req_s  = (state_r == ST_REQ);
    assign done_s    = (in_req_s && m_addr_ok && m_data_ok) ||
                       ((state_r == ST_WAIT) && m_data_ok);

    assign inst_addr_ok = in_idle_s && inst_req && (pick_grant_s == GNT_INST);
    assign data_addr_ok = in_idle_s && data_req && (pick_grant_s == GNT_DATA);
    assign inst_data_ok = done_s && (grant_r == GNT_INST);
    assign data_data_ok = done_s && (grant_r == GNT_DATA);
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

    // Master request fields come straight from the capture registers while in REQ.
    assign m_req   = in_req_s;
    assign m_wr    = in_req_s ? wr_r    : 1'b0;
    assign m_size  = in_req_s ? size_r  : 2'b00;
    assign m_addr  = in_req_s ? addr_r  : 32'h0000_0000;
    assign m_wdata = in_req_s ? wdata_r : 32'h0000_0000;

    // Transaction FSM: accept in IDLE, present in REQ, wait for data in WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            grant_r      <= GNT_INST;
            starve_cnt_r <= {CNT_W{1'b0}};
            wr_r         <= 1'b0;
            size_r       <= 2'b00;
            addr_r       <= 32'h0000_0000;
            wdata_r      <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        grant_r      <= pick_grant_s;
                        starve_cnt_r <= cnt_next_s;
                        if (pick_grant_s == GNT_DATA) begin
                            wr_r    <= data_wr;
                            size_r  <= data_size;
                            addr_r  <= data_addr;
                            wdata_r <= data_wdata;
                        end else begin
                            wr_r    <= inst_wr;
                            size_r  <= inst_size;
                            addr_r  <= inst_addr;
                            wdata_r <= inst_wdata;
                        end
                        state_r <= ST_REQ;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (m_addr_ok) begin
                        state_r <= m_data_ok ? ST_IDLE : ST_WAIT;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (m_data_ok) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
